// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
//   Issue/writeback controller wrapped around an external 32-bit ALU.
//   Holds an 8 x 32 register file. It accepts 3-operand instructions over a
//   valid/ready handshake and drives opcode/operands to the ALU. It samples
//   the ALU result and flags after EXEC_CYCLES cycles, then writes rd and the
//   status flags in a single writeback cycle.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   instr_valid/instr_ready         instruction handshake
//   instr_op/rd/rs1/rs2             opcode and register addresses
//   ld_en/ld_addr/ld_data           direct register load, honoured in IDLE only
//   alu_op/alu_a/alu_b              registered ALU inputs, held outside EXEC
//   alu_result, alu_overflow/zero/neg/carry   ALU outputs
//   flag_v/z/n/c                    registered status flags
//   done                            one-cycle pulse during writeback
//   busy                            controller not in IDLE
//   dbg_addr/dbg_data               combinational register file read port
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for an instruction; direct loads accepted
// EXEC  | operands held on the ALU for EXEC_CYCLES cycles
// WB    | result written to rd, flags updated, done pulsed

module alu_exec_ctrl #(
    parameter int EXEC_CYCLES = 1,
    parameter int NREGS       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_op,
    input  logic [2:0]  instr_rd,
    input  logic [2:0]  instr_rs1,
    input  logic [2:0]  instr_rs2,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_carry,
    output logic        flag_v,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_c,
    output logic        done,
    output logic        busy,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [2:0]  rd_q;
    logic [31:0] res_q;
    logic [3:0]  flg_q;
    logic [31:0] regs [NREGS];
    logic        accept;
    logic        ld_ok;
    logic [31:0] opa_rd, opb_rd;

    assign accept = (state == IDLE) && instr_valid;
    assign ld_ok  = (state == IDLE) && ld_en;

    // Operands are launched on the accept edge so they are already stable in
    // the first EXEC cycle. A load landing on that same edge must still be
    // seen by the instruction, so it is forwarded here.
    assign opa_rd = (ld_ok && (ld_addr == instr_rs1)) ? ld_data : regs[instr_rs1];
    assign opb_rd = (ld_ok && (ld_addr == instr_rs2)) ? ld_data : regs[instr_rs2];

    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rd_q   <= '0;
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            res_q  <= '0;
            flg_q  <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                rd_q   <= instr_rd;
                alu_op <= instr_op;
                alu_a  <= opa_rd;
                alu_b  <= opb_rd;
            end else if (state == EXEC) begin
                cnt <= cnt + 4'd1;
                if (cnt == CNT_LAST) begin
                    res_q <= alu_result;
                    flg_q <= {alu_overflow, alu_zero, alu_neg, alu_carry};
                end
            end
        end
    end

    // Loads happen only in IDLE and writeback only in WB, so the two write
    // sources never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (ld_ok) begin
            regs[ld_addr] <= ld_data;
        end else if (state == WB) begin
            regs[rd_q] <= res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == WB) begin
            {flag_v, flag_z, flag_n, flag_c} <= flg_q;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

    localparam int EXEC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op, instr_rd, instr_rs1, instr_rs2;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_overflow, alu_zero, alu_neg, alu_carry;
    logic        flag_v, flag_z, flag_n, flag_c;
    logic        done, busy;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.EXEC_CYCLES(EXEC), .NREGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
        .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .done(done), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: carry is carry-out for ADD and borrow for SUB,
    // overflow is signed overflow for ADD/SUB, both zero for other ops.
    logic [32:0] sum33;
    always_comb begin
        sum33        = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        case (alu_op)
            3'd0: begin
                sum33        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum33[31:0];
                alu_carry    = sum33[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'd1: alu_result = alu_a ^ alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = ~(alu_a | alu_b);
            3'd5: alu_result = alu_a << alu_b[4:0];
            3'd6: alu_result = alu_a >> alu_b[4:0];
            default: begin
                alu_result   = alu_a - alu_b;
                alu_carry    = alu_a < alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_neg  = alu_result[31];
    end

    typedef struct packed {
        logic [2:0]  rd;
        logic [31:0] res;
        logic [3:0]  flg;   // {v,z,n,c}
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic        dbg_req = 1'b0;
    logic [2:0]  stim_addr = '0;
    logic [2:0]  mon_addr = '0;
    assign dbg_addr = dbg_req ? stim_addr : mon_addr;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endfunction

    // Monitor: pops an expectation on each done pulse; the register and
    // flag write lands on the following edge, so they are checked one
    // cycle later.
    logic pending = 1'b0;
    exp_t cur;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    chk("wb_data", dbg_data, cur.res);
                    chk("wb_flags", {28'd0, flag_v, flag_z, flag_n, flag_c}, {28'd0, cur.flg});
                    pending = 1'b0;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        cur      = exp_q.pop_front();
                        mon_addr = cur.rd;
                        pending  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic dbg_check(input logic [2:0] a, input logic [31:0] v, input string name);
        dbg_req   = 1'b1;
        stim_addr = a;
        #1;
        chk(name, dbg_data, v);
        dbg_req = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || pending || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Issues one instruction; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [31:0] res, input logic [3:0] flg,
                         input bit expect_wb);
        exp_t e;
        wait_ready();
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        e.rd = rd; e.res = res; e.flg = flg;
        if (expect_wb) exp_q.push_back(e);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    initial begin
        int   lat;
        exp_t e;
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 8; i++) dbg_check(3'(i), 32'd0, "reset_reg");
        chk("reset_flags", {28'd0, flag_v, flag_z, flag_n, flag_c}, 32'd0);
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);

        // ADD overflow into sign bit, plus latency from accept to done
        load(3'd1, 32'h7FFF_FFFF);
        load(3'd2, 32'h0000_0001);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 32'h8000_0000, 4'b1010, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        chk("add_latency", 32'(lat), 32'(EXEC + 1));
        wait_idle();

        // SUB / XOR producing zero
        load(3'd4, 32'h1234_5678);
        issue(3'd7, 3'd5, 3'd4, 3'd4, 32'h0, 4'b0100, 1'b1);
        issue(3'd1, 3'd6, 3'd4, 3'd4, 32'h0, 4'b0100, 1'b1);
        wait_idle();

        // Back-to-back: OR then NOR with instr_valid held high throughout
        wait_ready();
        instr_valid = 1'b1;
        instr_op = 3'd3; instr_rd = 3'd1; instr_rs1 = 3'd4; instr_rs2 = 3'd3;
        e.rd = 3'd1; e.res = 32'h9234_5678; e.flg = 4'b0010;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        instr_op = 3'd4; instr_rd = 3'd2; instr_rs1 = 3'd5; instr_rs2 = 3'd5;
        for (int k = 1; k <= EXEC; k++) begin
            @(negedge clk);
            chk("b2b_alu_a", alu_a, 32'h1234_5678);
            chk("b2b_alu_b", alu_b, 32'h8000_0000);
            chk("b2b_no_done", {31'd0, done}, 32'd0);
            chk("b2b_not_ready", {31'd0, instr_ready}, 32'd0);
        end
        @(negedge clk);
        chk("b2b_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("b2b_ready", {31'd0, instr_ready}, 32'd1);
        chk("b2b_done_off", {31'd0, done}, 32'd0);
        e.rd = 3'd2; e.res = 32'hFFFF_FFFF; e.flg = 4'b0010;
        exp_q.push_back(e);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_accept", {31'd0, busy}, 32'd1);
        chk("b2b_alu_op", {29'd0, alu_op}, 32'd4);
        wait_idle();

        // Load while busy is dropped
        issue(3'd2, 3'd0, 3'd4, 3'd2, 32'h1234_5678, 4'b0000, 1'b1);
        load(3'd2, 32'h0000_0010);
        wait_idle();
        dbg_check(3'd2, 32'hFFFF_FFFF, "busy_load_dropped");

        // Load and instruction in the same IDLE cycle: instruction sees new r2
        wait_ready();
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'h0000_0100;
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd0;
        instr_rs1 = 3'd2; instr_rs2 = 3'd3;
        e.rd = 3'd0; e.res = 32'h8000_0100; e.flg = 4'b0010;
        exp_q.push_back(e);
        @(posedge clk);
        #1 begin ld_en = 1'b0; instr_valid = 1'b0; end
        wait_idle();
        dbg_check(3'd2, 32'h0000_0100, "idle_load");

        // Shifts
        load(3'd5, 32'd4);
        issue(3'd5, 3'd6, 3'd4, 3'd5, 32'h2345_6780, 4'b0000, 1'b1);
        issue(3'd6, 3'd7, 3'd4, 3'd5, 32'h0123_4567, 4'b0000, 1'b1);
        wait_idle();

        // Reset during EXEC aborts the instruction
        issue(3'd0, 3'd7, 3'd1, 3'd2, 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        chk("abort_in_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (EXEC + 4) @(negedge clk);
        chk("abort_idle", {31'd0, instr_ready}, 32'd1);
        chk("abort_flags", {28'd0, flag_v, flag_z, flag_n, flag_c}, 32'd0);
        dbg_check(3'd7, 32'd0, "abort_r7");
        dbg_check(3'd1, 32'd0, "abort_r1_cleared");
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Issue/writeback controller that sits directly upstream and downstream of the 32-bit ALU.
- Holds an 8-entry x 32-bit register file and accepts 3-operand instructions (op, rd, rs1, rs2) over a valid/ready handshake.
- Drives the ALU opcode and operands, samples the ALU result and flags after a programmable settle time, then writes rd and a status flag register.

Parameters:
- EXEC_CYCLES, 1, cycles operands are held stable on the ALU before sampling (legal 1..15)
- NREGS, 8, register file depth (fixed; 3-bit addresses)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept instruction
- instr_op  in  3  ALU opcode: 0 ADD, 1 XOR, 2 AND, 3 OR, 4 NOR, 5 SL, 6 SR, 7 SUB
- instr_rd  in  3  destination register
- instr_rs1  in  3  source A register
- instr_rs2  in  3  source B register
- ld_en  in  1  direct register load strobe
- ld_addr  in  3  load target
- ld_data  in  32  load value
- alu_op  out  3  opcode to ALU
- alu_a  out  32  operand A to ALU
- alu_b  out  32  operand B to ALU
- alu_result  in  32  ALU result
- alu_overflow, alu_zero, alu_neg, alu_carry  in  1 each  ALU flags
- flag_v, flag_z, flag_n, flag_c  out  1 each  registered status flags
- done  out  1  one-cycle pulse in writeback cycle
- busy  out  1  state != IDLE
- dbg_addr  in  3  debug read address
- dbg_data  out  32  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, rst_n=0): all 8 registers = 0, flags = 0, state = IDLE, alu_op/alu_a/alu_b = 0, done = 0, cycle counter = 0. Reset mid-operation aborts the instruction with no register or flag write.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch op/rd/rs1/rs2, go to EXEC, counter = 0.
  - EXEC: first EXEC cycle registers alu_op=op, alu_a=reg[rs1], alu_b=reg[rs2]. These are held constant for exactly EXEC_CYCLES cycles, with the counter incrementing each cycle. Leave when counter == EXEC_CYCLES-1; sample alu_result and flags on that edge into holding registers. Go to WB.
  - WB: reg[rd] <= sampled result; flag_v/z/n/c <= sampled flags; done=1 for this cycle only. Next state IDLE.
- Latency: accept edge -> EXEC_CYCLES EXEC cycles -> 1 WB cycle. A new instruction is accepted at the earliest in the cycle after WB. Throughput is 1 per EXEC_CYCLES+2 cycles.
- alu_op/alu_a/alu_b retain their last values in IDLE and WB (no toggling outside EXEC).
- Operands are read from the register file at EXEC entry, not at accept. A ld_en in the accept cycle is therefore visible to that instruction.
- ld_en is honoured only when state==IDLE; it is ignored (dropped) otherwise. ld_en and instr_valid in the same IDLE cycle are both accepted.
- rd may equal rs1/rs2; the result overwrites only in WB.
- All 8 registers are writable; there is no hardwired zero.
- Flags are the registered ALU flags verbatim. Flags change only in WB; ld_en never affects flags.
- dbg_data reflects writes from the edge after they occur.
- instr_* inputs are don't-care while instr_ready=0.

Test Plan:
- Reset, then dbg_addr sweep 0..7 -> dbg_data=0 for all; flags=0, instr_ready=1, busy=0.
- ld r1=0x7FFFFFFF, r2=0x00000001; ADD rd=3 -> done after EXEC_CYCLES+1 cycles from accept, r3=0x80000000, flag_n=1, flag_z=0.
- ld r4=0x12345678; SUB rd=5, rs1=4, rs2=4 -> r5=0, flag_z=1; next XOR r6=r4^r4 -> r6=0, flag_z=1.
- EXEC_CYCLES=3: accept at cycle t -> alu_a/alu_b stable cycles t+1..t+3, done=1 only at t+4, instr_ready=1 at t+5; instr_valid held high back-to-back -> second accept at t+5.
- ld_en to r2 while busy=1 -> r2 unchanged; same ld_en together with instr_valid in IDLE (rs1=2) -> instruction uses the new value.
- Assert rst_n=0 during EXEC of ADD rd=7 -> r7=0, done never pulses, state IDLE, flags 0.
